// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - Buffered 8N1 UART transmitter with an internal byte FIFO.
// Optional even-parity bit after the data byte when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 27000000,
    parameter int FIFO_AW    = 3
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               wr_valid,
    input  logic [7:0]         wr_data,
    output logic               wr_ready,
    input  logic               clr_overflow,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int              DEPTH    = 1 << FIFO_AW;
    localparam logic [31:0]     DIV_M1   = 32'(CLOCK_FREQ / BAUD_RATE - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               overflow_q;

    state_t             state_q, state_d;
    logic [31:0]        baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;

    logic full, empty, accept, pop, bit_done;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign accept   = wr_valid && !full;
    assign bit_done = (baud_q == DIV_M1);

    assign wr_ready   = !full;
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || !empty;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A fresh overflow event takes priority over a clear request.
            if (wr_valid && full) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        // Every bit period restarts the counter at zero on entry.
        if (state_q != S_IDLE) begin
            baud_d = bit_done ? '0 : baud_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = ^shift_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - Self-checking bench for uart_tx_fifo with a line-decoding reference monitor.
module tb_uart_tx_fifo;

    localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_overflow = 1'b0;
    logic       wr_ready;
    logic       tx;
    logic       busy;
    logic [3:0] fifo_count;
    logic       overflow;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    uart_tx_fifo #(
        .BAUD_RATE  (1),
        .CLOCK_FREQ (16),
        .FIFO_AW    (3)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .clr_overflow (clr_overflow),
        .tx           (tx),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Reference line decoder: finds start edges, samples mid-bit, and flags any
    // level change that is not on a DIV boundary.
    int         start_q[$];
    logic [7:0] byte_q[$];
    logic       par_q[$];
    int         frame_errs = 0;
    bit         mon_active = 1'b0;
    int         mon_pos = 0;
    logic       prev_tx = 1'b1;
    logic [7:0] mon_byte = 8'h00;

    always @(negedge sys_clk) begin
        int k;
        if (!sys_rst_n) begin
            mon_active = 1'b0;
            prev_tx    = 1'b1;
        end else begin
            if (!mon_active) begin
                if (tx === 1'b0 && prev_tx === 1'b1) begin
                    mon_active = 1'b1;
                    mon_pos    = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                mon_pos++;
                if ((mon_pos % DIV) != 0 && tx !== prev_tx) frame_errs++;
            end
            if (mon_active && (mon_pos % DIV) == DIV / 2) begin
                k = mon_pos / DIV;
                if (k == 0) begin
                    if (tx !== 1'b0) frame_errs++;
                end else if (k <= 8) begin
                    mon_byte = {tx, mon_byte[7:1]};
                end else if (k == NBITS - 1) begin
                    if (tx !== 1'b1) frame_errs++;
                    byte_q.push_back(mon_byte);
                    mon_active = 1'b0;
                end else begin
                    par_q.push_back(tx);
                end
            end
            prev_tx = tx;
        end
    end

    task automatic clear_mon();
        start_q.delete();
        byte_q.delete();
        par_q.delete();
        frame_errs = 0;
    endtask

    task automatic push_byte(input logic [7:0] b, output int t_acc);
        wr_valid = 1'b1;
        wr_data  = b;
        @(negedge sys_clk);
        t_acc = cyc;
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0;
        wr_data  = 8'($urandom);
    endtask

    task automatic wait_idle(input int limit, output int t_idle, output bit ok);
        ok = 1'b0;
        t_idle = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge sys_clk);
            if (!busy) begin
                ok = 1'b1;
                t_idle = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int e, t;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (fifo_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        clear_mon();
        push_byte(8'hA5, e);
        push_byte(8'h3C, t);
        push_byte(8'h96, t);
        idle_inputs();
        while (cyc < e + 1 + 4 * DIV + 5) @(negedge sys_clk);
        checks++; if (tx !== 1'b0) begin fails++; $display("FAIL midframe_bit3: got %b want 0", tx); end
        #2 sys_rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin fails++; $display("FAIL async_reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL async_reset_busy: got %b want 0", busy); end
        checks++; if (fifo_count !== 4'd0) begin fails++; $display("FAIL async_reset_count: got %0d want 0", fifo_count); end
        @(negedge sys_clk);
        #3 sys_rst_n = 1'b1;
        clear_mon();
        repeat (300) @(negedge sys_clk);
        checks++; if (start_q.size() != 0) begin fails++; $display("FAIL post_reset_activity: got %0d starts want 0", start_q.size()); end
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got tx=%b busy=%b want tx=1 busy=0", tx, busy); end
    endtask

    task automatic test_single(input logic [7:0] b);
        int e, t, s0;
        bit ok;
        logic [7:0] got;
        clear_mon();
        push_byte(b, e);
        idle_inputs();
        wait_idle(FRAME + 100, t, ok);
        checks++; if (!ok) begin fails++; $display("FAIL single_timeout: got busy stuck want idle by %0d cycles", FRAME + 100); end
        checks++; if (t != e + 1 + FRAME) begin fails++; $display("FAIL single_busy_drop: got cycle %0d want %0d", t, e + 1 + FRAME); end
        s0 = (start_q.size() > 0) ? start_q[0] : -1;
        checks++; if (start_q.size() != 1 || s0 != e + 1) begin fails++; $display("FAIL single_start: got %0d starts first %0d want 1 at %0d", start_q.size(), s0, e + 1); end
        got = (byte_q.size() > 0) ? byte_q[0] : 8'hxx;
        checks++; if (byte_q.size() != 1 || got !== b) begin fails++; $display("FAIL single_byte: got %h (n=%0d) want %h", got, byte_q.size(), b); end
        checks++; if (frame_errs != 0) begin fails++; $display("FAIL single_framing: got %0d errors want 0", frame_errs); end
`ifdef UART_TX_PARITY_EN
        checks++; if (par_q.size() != 1 || par_q[0] !== ^b) begin fails++; $display("FAIL parity_bit: got n=%0d want bit %b for %h", par_q.size(), ^b, b); end
`endif
    endtask

    task automatic test_burst();
        logic [7:0] bytes[3] = '{8'h01, 8'h80, 8'hFF};
        int e, t, peak, s;
        bit ok;
        clear_mon();
        peak = 0;
        for (int i = 0; i < 3; i++) begin
            push_byte(bytes[i], t);
            if (i == 0) e = t;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        idle_inputs();
        repeat (20) begin
            @(negedge sys_clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        checks++; if (peak != 2) begin fails++; $display("FAIL burst_peak: got %0d want 2", peak); end
        wait_idle(3 * FRAME + 100, t, ok);
        checks++; if (!ok || t != e + 1 + 3 * FRAME) begin fails++; $display("FAIL burst_busy_drop: got %0d want %0d", t, e + 1 + 3 * FRAME); end
        checks++; if (start_q.size() != 3) begin fails++; $display("FAIL burst_starts: got %0d want 3", start_q.size()); end
        for (int i = 0; i < 3; i++) begin
            s = (i < start_q.size()) ? start_q[i] : -1;
            checks++; if (s != e + 1 + i * FRAME) begin fails++; $display("FAIL burst_start_%0d: got %0d want %0d", i, s, e + 1 + i * FRAME); end
            checks++; if (i >= byte_q.size() || byte_q[i] !== bytes[i]) begin fails++; $display("FAIL burst_byte_%0d: got n=%0d want %h", i, byte_q.size(), bytes[i]); end
        end
        checks++; if (frame_errs != 0) begin fails++; $display("FAIL burst_framing: got %0d errors want 0", frame_errs); end
    endtask

    task automatic test_fill();
        logic [7:0] b[10];
        int t, expc;
        bit ok;
        clear_mon();
        for (int i = 0; i < 10; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 10; i++) begin
            clr_overflow = (i == 9);
            push_byte(b[i], t);
            clr_overflow = 1'b0;
            expc = (i == 0) ? 1 : ((i < 9) ? i : 8);
            checks++; if (int'(fifo_count) != expc) begin fails++; $display("FAIL fill_count_%0d: got %0d want %0d", i, fifo_count, expc); end
            if (i == 8) begin
                checks++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL fill_wr_ready: got %b want 0", wr_ready); end
                checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL fill_no_overflow: got %b want 0", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_set_wins: got %b want 1", overflow); end
        idle_inputs();
        @(negedge sys_clk);
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
        clr_overflow = 1'b1;
        @(negedge sys_clk);
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL overflow_clear: got %b want 0", overflow); end
        wait_idle(9 * FRAME + 100, t, ok);
        checks++; if (!ok) begin fails++; $display("FAIL fill_timeout: got busy stuck want idle"); end
        checks++; if (byte_q.size() != 9) begin fails++; $display("FAIL fill_frames: got %0d want 9", byte_q.size()); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (i >= byte_q.size() || byte_q[i] !== b[i]) begin fails++; $display("FAIL fill_byte_%0d: got n=%0d want %h", i, byte_q.size(), b[i]); end
        end
        checks++; if (frame_errs != 0) begin fails++; $display("FAIL fill_framing: got %0d errors want 0", frame_errs); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] b[3];
        int e, t, s;
        bit ok;
        clear_mon();
        for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
        push_byte(b[0], e);
        push_byte(b[1], t);
        idle_inputs();
        while (cyc < e + FRAME) @(negedge sys_clk);
        checks++; if (fifo_count !== 4'd1) begin fails++; $display("FAIL simul_pre_count: got %0d want 1", fifo_count); end
        push_byte(b[2], t);
        idle_inputs();
        checks++; if (fifo_count !== 4'd1) begin fails++; $display("FAIL simul_count: got %0d want 1", fifo_count); end
        wait_idle(3 * FRAME + 100, t, ok);
        checks++; if (!ok || byte_q.size() != 3) begin fails++; $display("FAIL simul_frames: got %0d want 3", byte_q.size()); end
        for (int i = 0; i < 3; i++) begin
            s = (i < start_q.size()) ? start_q[i] : -1;
            checks++; if (s != e + 1 + i * FRAME) begin fails++; $display("FAIL simul_start_%0d: got %0d want %0d", i, s, e + 1 + i * FRAME); end
            checks++; if (i >= byte_q.size() || byte_q[i] !== b[i]) begin fails++; $display("FAIL simul_byte_%0d: got n=%0d want %h", i, byte_q.size(), b[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int n, t;
        bit ok;
        for (int r = 0; r < 3; r++) begin
            clear_mon();
            exp_q.delete();
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 40)) @(negedge sys_clk);
                b = 8'($urandom);
                push_byte(b, t);
                exp_q.push_back(b);
                idle_inputs();
            end
            wait_idle(8 * FRAME + 200, t, ok);
            checks++; if (!ok || byte_q.size() != exp_q.size()) begin fails++; $display("FAIL random_%0d_frames: got %0d want %0d", r, byte_q.size(), exp_q.size()); end
            for (int j = 0; j < exp_q.size(); j++) begin
                checks++; if (j >= byte_q.size() || byte_q[j] !== exp_q[j]) begin fails++; $display("FAIL random_%0d_byte_%0d: got n=%0d want %h", r, j, byte_q.size(), exp_q[j]); end
            end
            checks++; if (overflow !== 1'b0 || frame_errs != 0) begin fails++; $display("FAIL random_%0d_status: got ovf=%b errs=%0d want 0 0", r, overflow, frame_errs); end
        end
    endtask

    initial begin
        test_reset();
        test_single(8'h55);
        test_single(8'($urandom));
        test_burst();
        test_fill();
        test_simultaneous();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_single(8'h07);
        test_single(8'h03);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
